// File: rtl/flex_fifo_ctrl.sv
// Single-clock FIFO with occupancy/threshold status, sticky error flags,
// synchronous flush and selectable registered or fall-through read port.
module flex_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_THRESH);

  if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH ||
      DATA_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_param_check
    $error("flex_fifo_ctrl: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic full_q, full_d, empty_q, empty_d;
  logic af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic wr_acc, rd_acc;

  // Flush wins over both requests, so neither side is accepted in a clear cycle.
  assign wr_acc = wen && !full_q && !clear;
  assign rd_acc = ren && !empty_q && !clear;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      if (wen && full_q)  ovf_d = 1'b1;
      if (ren && empty_q) unf_d = 1'b1;
    end
    // The wrap bits make the pointer difference an exact occupancy 0..DEPTH.
    count_d = wptr_d - rptr_d;
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_CNT);
    ae_d    = (count_d <= AE_CNT);
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_acc) mem[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; masked to zero while nothing is stored.
    assign rdata  = empty_q ? '0 : mem[rptr_q[ADDR_WIDTH-1:0]];
    assign rvalid = !empty_q;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_flex_fifo_ctrl.sv
// Scoreboard bench: a registered-read instance driven through a behavioural
// occupancy model, plus a fall-through instance exercised directly.
module tb_flex_fifo_ctrl;

  logic       wclk = 1'b0;
  logic       rst;
  logic       clear, wen, ren;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid, full, empty, almostFull, almostEmpty, overflow, underflow;
  logic [2:0] count;

  logic       clear1, wen1, ren1;
  logic [7:0] wdata1;
  logic [7:0] rdata1;
  logic       rvalid1, full1, empty1, almostFull1, almostEmpty1, overflow1, underflow1;
  logic [2:0] count1;

  int checks = 0;
  int errors = 0;

  int         mCount;
  bit         mOvf, mUnf;
  logic [7:0] sb[$];
  bit         expValid;
  logic [7:0] expData, lastData;

  flex_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) dutReg (
    .wclk(wclk), .rst(rst), .clear(clear), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almostFull), .almost_empty(almostEmpty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  flex_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) dutFwft (
    .wclk(wclk), .rst(rst), .clear(clear1), .wen(wen1), .wdata(wdata1), .ren(ren1),
    .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1),
    .almost_full(almostFull1), .almost_empty(almostEmpty1), .count(count1),
    .overflow(overflow1), .underflow(underflow1)
  );

  always #5 wclk = ~wclk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Compares every registered-read output against the model after an edge.
  task automatic checkState(input string phase);
    checkOutput({phase, ".count"},        32'(count),        32'(mCount));
    checkOutput({phase, ".full"},         32'(full),         32'(mCount == 4));
    checkOutput({phase, ".empty"},        32'(empty),        32'(mCount == 0));
    checkOutput({phase, ".almost_full"},  32'(almostFull),   32'(mCount >= 3));
    checkOutput({phase, ".almost_empty"}, 32'(almostEmpty),  32'(mCount <= 1));
    checkOutput({phase, ".overflow"},     32'(overflow),     32'(mOvf));
    checkOutput({phase, ".underflow"},    32'(underflow),    32'(mUnf));
    checkOutput({phase, ".rvalid"},       32'(rvalid),       32'(expValid));
    checkOutput({phase, ".rdata"},        32'(rdata),        32'(expValid ? expData : lastData));
    if (expValid) lastData = expData;
  endtask

  task automatic applyStimulus(input string phase, input bit w, input logic [7:0] d,
                               input bit r, input bit c);
    bit wAcc, rAcc;
    @(negedge wclk);
    wen = w; wdata = d; ren = r; clear = c;
    expValid = 1'b0;
    if (c) begin
      mCount = 0; mOvf = 1'b0; mUnf = 1'b0;
      sb.delete();
    end else begin
      rAcc = r && (mCount != 0);
      wAcc = w && (mCount != 4);
      if (w && !wAcc) mOvf = 1'b1;
      if (r && !rAcc) mUnf = 1'b1;
      if (rAcc) begin
        expData  = sb.pop_front();
        expValid = 1'b1;
        mCount--;
      end
      if (wAcc) begin
        sb.push_back(d);
        mCount++;
      end
    end
    @(posedge wclk);
    #1;
    wen = 1'b0; ren = 1'b0; clear = 1'b0;
    checkState(phase);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
    clear1 = 1'b0; wen1 = 1'b0; ren1 = 1'b0; wdata1 = '0;
    mCount = 0; mOvf = 1'b0; mUnf = 1'b0; expValid = 1'b0; expData = '0; lastData = '0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    rst = 1'b0;
    #1;
    checkState("reset");
    checkOutput("reset.fwft_rvalid", 32'(rvalid1), 32'd0);
    checkOutput("reset.fwft_empty",  32'(empty1),  32'd1);

    // Fill then drain with idle gaps so each rvalid pulse is seen to drop.
    applyStimulus("fill", 1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus("fill", 1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus("fill", 1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus("fill", 1'b1, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("drain", 1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus("drain_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Simultaneous write and read while full.
    applyStimulus("ovf_fill", 1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus("ovf_fill", 1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus("ovf_fill", 1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus("ovf_fill", 1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus("ovf_both", 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("ovf_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("ovf_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous write and read while empty.
    applyStimulus("unf_both", 1'b1, 8'hA5, 1'b1, 1'b0);
    applyStimulus("unf_read", 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("unf_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("clear0",   1'b0, 8'h00, 1'b0, 1'b1);

    // Interleaved traffic keeping occupancy in 1..2 across many pointer wraps.
    applyStimulus("wrap_w", 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      applyStimulus("wrap_w", 1'b1, 8'(i), 1'b0, 1'b0);
      applyStimulus("wrap_r", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    applyStimulus("wrap_r", 1'b0, 8'h00, 1'b1, 1'b0);

    // Clear with count 3 and overflow set; the concurrent write must be dropped.
    applyStimulus("clr_fill", 1'b1, 8'h61, 1'b0, 1'b0);
    applyStimulus("clr_fill", 1'b1, 8'h62, 1'b0, 1'b0);
    applyStimulus("clr_fill", 1'b1, 8'h63, 1'b0, 1'b0);
    applyStimulus("clr_fill", 1'b1, 8'h64, 1'b0, 1'b0);
    applyStimulus("clr_ovf",  1'b1, 8'h65, 1'b0, 1'b0);
    applyStimulus("clr_pop",  1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("clr_wen",  1'b1, 8'h66, 1'b0, 1'b1);
    applyStimulus("clr_after", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle with two words stored.
    applyStimulus("arst_fill", 1'b1, 8'h71, 1'b0, 1'b0);
    applyStimulus("arst_fill", 1'b1, 8'h72, 1'b0, 1'b0);
    applyStimulus("arst_pop",  1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("arst_fill", 1'b1, 8'h73, 1'b0, 1'b0);
    @(negedge wclk);
    #2;
    rst = 1'b1;
    #1;
    mCount = 0; mOvf = 1'b0; mUnf = 1'b0; sb.delete();
    expValid = 1'b0; lastData = '0;
    checkState("arst");
    @(negedge wclk);
    rst = 1'b0;
    applyStimulus("arst_post", 1'b1, 8'h81, 1'b0, 1'b0);
    applyStimulus("arst_post", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fall-through instance: head word appears without a read request.
    @(negedge wclk);
    wen1 = 1'b1; wdata1 = 8'h7E;
    @(posedge wclk);
    #1;
    wen1 = 1'b0;
    checkOutput("fwft.rvalid", 32'(rvalid1), 32'd1);
    checkOutput("fwft.rdata",  32'(rdata1),  32'h7E);
    checkOutput("fwft.count",  32'(count1),  32'd1);
    @(posedge wclk);
    #1;
    checkOutput("fwft.hold_rvalid", 32'(rvalid1), 32'd1);
    checkOutput("fwft.hold_rdata",  32'(rdata1),  32'h7E);
    @(negedge wclk);
    ren1 = 1'b1;
    @(posedge wclk);
    #1;
    ren1 = 1'b0;
    checkOutput("fwft.pop_rvalid", 32'(rvalid1), 32'd0);
    checkOutput("fwft.pop_empty",  32'(empty1),  32'd1);
    checkOutput("fwft.underflow",  32'(underflow1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
